// File: rtl/tqvp_byte_sched_pkg.sv
// Package: tqvp_byte_sched_pkg
// Purpose: shared definitions for the byte write scheduler. It holds the
//          register map addresses, the CTRL/STATUS bit positions, the queue
//          entry layout and the scheduler FSM state encoding.
// Ports:   none (package)
package tqvp_byte_sched_pkg;

    // Register map (byte-peripheral address window)
    localparam logic [3:0] QUEUE_MAX = 4'hB;  // 0x0..0xB push into the queue
    localparam logic [3:0] CTRL      = 4'hC;
    localparam logic [3:0] PACE      = 4'hD;
    localparam logic [3:0] STATUS    = 4'hE;
    localparam logic [3:0] LAST      = 4'hF;

    // CTRL bits
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;

    // STATUS bits: {enable, busy, overflow, full, empty, count[2:0]}
    localparam int STAT_ENABLE   = 7;
    localparam int STAT_BUSY     = 6;
    localparam int STAT_OVERFLOW = 5;  // also the write-1-to-clear bit
    localparam int STAT_FULL     = 4;
    localparam int STAT_EMPTY    = 3;

    // One queued register write
    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/tqvp_byte_sched_fifo.sv
// Module: tqvp_byte_sched_fifo
// Purpose: synchronous FIFO of 12-bit {addr,data} entries, FIFO_DEPTH deep.
//          Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Flush wins
//          over a push or pop in the same cycle.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   push        write push_data (ignored when full or flushing)
//   push_data   entry to store
//   pop         advance the read pointer (ignored when empty or flushing)
//   flush       empty the queue at the next edge
//   head        entry at the read pointer
//   count       number of stored entries
//   full, empty occupancy flags from the current count
module tqvp_byte_sched_fifo
    import tqvp_byte_sched_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    localparam int PW         = $clog2(FIFO_DEPTH),
    localparam int CW         = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output entry_t        head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    entry_t        mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tqvp_byte_write_sched.sv
// Module: tqvp_byte_write_sched
// Purpose: TinyQV byte peripheral that queues CPU register writes and replays
//          them, paced, to a downstream byte-wide register port.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   ui_in       input PMOD (unused)
//   uo_out      {enable,busy,overflow,full,empty,3'b0}
//   address     peripheral register address
//   data_write  one-cycle write strobe
//   data_in     write data
//   data_out    read data for address (combinational)
//   reg_addr    downstream register address
//   reg_data    downstream write data
//   reg_we      downstream write request, held until reg_ready
//   reg_ready   downstream accept
module tqvp_byte_write_sched
    import tqvp_byte_sched_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] PACE_RST   = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic [3:0] reg_addr,
    output logic [7:0] reg_data,
    output logic       reg_we,
    input  logic       reg_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state;
    logic          enable;
    logic          overflow;
    logic [7:0]    pace_reg;
    logic [7:0]    pace_cnt;
    logic [3:0]    last_addr;

    entry_t        head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [3:0]    count_ext;
    logic [7:0]    status;

    logic queue_wr, ctrl_wr, pace_wr, status_wr, flush, start_issue;

    assign queue_wr  = data_write && (address <= QUEUE_MAX);
    assign ctrl_wr   = data_write && (address == CTRL);
    assign pace_wr   = data_write && (address == PACE);
    assign status_wr = data_write && (address == STATUS);
    assign flush     = ctrl_wr && data_in[CTRL_FLUSH];
    // A flushing cycle must not launch the head entry it is discarding.
    assign start_issue = (state == IDLE) && enable && !fifo_empty && !flush;

    tqvp_byte_sched_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (queue_wr),
        .push_data ('{addr: address, data: data_in}),
        .pop       (start_issue),
        .flush     (flush),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Control / status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            enable    <= 1'b0;
            pace_reg  <= PACE_RST;
            overflow  <= 1'b0;
            last_addr <= '0;
        end else begin
            if (ctrl_wr) enable   <= data_in[CTRL_ENABLE];
            if (pace_wr) pace_reg <= data_in;
            // Dropped push sets overflow; set has priority over clear.
            if (queue_wr && fifo_full && !flush)
                overflow <= 1'b1;
            else if (status_wr && data_in[STAT_OVERFLOW])
                overflow <= 1'b0;
            if (state == ISSUE && reg_ready) last_addr <= reg_addr;
        end
    end

    // Issue FSM with registered downstream outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            reg_we   <= 1'b0;
            reg_addr <= '0;
            reg_data <= '0;
            pace_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_issue) begin
                        reg_addr <= head.addr;
                        reg_data <= head.data;
                        reg_we   <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (reg_ready) begin
                        reg_we <= 1'b0;
                        if (pace_reg == 8'd0) begin
                            state <= IDLE;
                        end else begin
                            pace_cnt <= pace_reg;  // snapshot: later PACE writes wait
                            state    <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (pace_cnt <= 8'd1) state <= IDLE;
                    else                  pace_cnt <= pace_cnt - 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign count_ext = 4'(fifo_count);
    assign status    = {enable, (state != IDLE), overflow, fifo_full, fifo_empty,
                        count_ext[2:0]};
    assign uo_out    = {status[7:3], 3'b000};

    // NOTE: every output of a combinational block gets a default first so no
    // address leaves it unassigned and no latch is inferred.
    always_comb begin
        data_out = 8'h00;
        case (address)
            CTRL:    data_out = {7'b0, enable};
            PACE:    data_out = pace_reg;
            STATUS:  data_out = status;
            LAST:    data_out = {4'b0, last_addr};
            default: data_out = 8'h00;
        endcase
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, ui_in, count_ext[3]};

endmodule

// File: tb/tb_tqvp_byte_write_sched.sv
// Testbench: tb_tqvp_byte_write_sched
// Purpose: directed scenarios for the byte write scheduler: reset, single
//          write latency, pacing with backpressure, overflow, flush and a
//          wrapping stream with simultaneous push/pop.
module tb_tqvp_byte_write_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic [3:0] reg_addr;
    logic [7:0] reg_data;
    logic       reg_we;
    logic       reg_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [11:0] got [$];  // completed downstream transfers {addr,data}

    tqvp_byte_write_sched #(.FIFO_DEPTH(4), .PACE_RST(8'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .reg_we     (reg_we),
        .reg_ready  (reg_ready)
    );

    always #5 clk = ~clk;

    // Pre-edge values are sampled here, so a handshake is seen exactly once.
    always @(posedge clk) begin
        if (!rst && reg_we && reg_ready) got.push_back({reg_addr, reg_data});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        step();
        data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        address = a;
        #1;
    endtask

    // Bounded wait for empty queue and idle FSM.
    task automatic wait_idle(input int max_cycles, input string name);
        int n = 0;
        while (!(uo_out[3] === 1'b1 && uo_out[6] === 1'b0) && n < max_cycles) begin
            step();
            n++;
        end
        vectors++;
        if (n >= max_cycles) begin
            miscompares++;
            $display("FAIL %s: idle not reached, uo_out=%h after %0d cycles", name, uo_out, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vectors++;
        if (reg_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b exp 0", reg_we); end
        vectors++;
        if ({reg_addr, reg_data} !== 12'h000) begin
            miscompares++; $display("FAIL reset_regout: got %h exp 000", {reg_addr, reg_data});
        end
        vectors++;
        if (uo_out !== 8'h08) begin miscompares++; $display("FAIL reset_uo: got %h exp 08", uo_out); end
        rd(4'hE);
        vectors++;
        if (data_out !== 8'h08) begin miscompares++; $display("FAIL reset_status: got %h exp 08", data_out); end
        rd(4'hD);
        vectors++;
        if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_pace: got %h exp 00", data_out); end
        rd(4'h0);
        vectors++;
        if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_dout0: got %h exp 00", data_out); end
    endtask

    task automatic test_single_write();
        got.delete();
        reg_ready = 1'b1;
        wr(4'hC, 8'h01);
        // cycle 0: push
        address = 4'h3; data_in = 8'hA5; data_write = 1'b1;
        step();
        data_write = 1'b0;
        // cycle 1
        vectors++;
        if (reg_we !== 1'b0) begin miscompares++; $display("FAIL single_c1_we: got %b exp 0", reg_we); end
        step();
        // cycle 2
        vectors++;
        if ({reg_we, reg_addr, reg_data} !== {1'b1, 4'h3, 8'hA5}) begin
            miscompares++;
            $display("FAIL single_c2: got we=%b a=%h d=%h exp we=1 a=3 d=a5", reg_we, reg_addr, reg_data);
        end
        step();
        // cycle 3
        vectors++;
        if (reg_we !== 1'b0) begin miscompares++; $display("FAIL single_c3_we: got %b exp 0", reg_we); end
        rd(4'hF);
        vectors++;
        if (data_out !== 8'h03) begin miscompares++; $display("FAIL single_last: got %h exp 03", data_out); end
        rd(4'hE);
        vectors++;
        if (data_out !== 8'h88) begin miscompares++; $display("FAIL single_status: got %h exp 88", data_out); end
    endtask

    task automatic test_pacing_backpressure();
        int low;
        got.delete();
        reg_ready = 1'b0;
        wr(4'hD, 8'd3);
        wr(4'h1, 8'h11);
        wr(4'h2, 8'h22);
        // First entry is now on the port; hold it with reg_ready low.
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({reg_we, reg_addr, reg_data} !== {1'b1, 4'h1, 8'h11}) begin
                miscompares++;
                $display("FAIL pace_hold%0d: got we=%b a=%h d=%h exp we=1 a=1 d=11", i, reg_we, reg_addr, reg_data);
            end
            step();
        end
        reg_ready = 1'b1;
        step();  // handshake of first entry
        low = 0;
        while (reg_we !== 1'b1 && low < 20) begin
            low++;
            step();
        end
        vectors++;
        if (low !== 4) begin miscompares++; $display("FAIL pace_gap: got %0d low cycles exp 4", low); end
        vectors++;
        if ({reg_addr, reg_data} !== {4'h2, 8'h22}) begin
            miscompares++; $display("FAIL pace_second: got %h exp 222", {reg_addr, reg_data});
        end
        step();
        wait_idle(20, "pace_idle");
        vectors++;
        if (got.size() != 2 || got[0] !== 12'h111 || got[1] !== 12'h222) begin
            miscompares++; $display("FAIL pace_order: got %0d transfers exp 2 (111,222)", got.size());
        end
        rd(4'hF);
        vectors++;
        if (data_out !== 8'h02) begin miscompares++; $display("FAIL pace_last: got %h exp 02", data_out); end
        wr(4'hD, 8'd0);
    endtask

    task automatic test_overflow();
        got.delete();
        wr(4'hC, 8'h00);
        for (int i = 0; i < 5; i++) wr(4'(4 + i), 8'(8'h40 + 8'(i) * 8'h10));
        vectors++;
        if (uo_out !== 8'h30) begin miscompares++; $display("FAIL ovf_uo: got %h exp 30", uo_out); end
        rd(4'hE);
        vectors++;
        if (data_out !== 8'h34) begin miscompares++; $display("FAIL ovf_status: got %h exp 34", data_out); end
        wr(4'hE, 8'h20);
        rd(4'hE);
        vectors++;
        if (data_out !== 8'h14) begin miscompares++; $display("FAIL ovf_clear: got %h exp 14", data_out); end
        reg_ready = 1'b1;
        wr(4'hC, 8'h01);
        wait_idle(40, "ovf_drain");
        vectors++;
        if (got.size() != 4 || got[0] !== 12'h440 || got[1] !== 12'h550 ||
            got[2] !== 12'h660 || got[3] !== 12'h770) begin
            miscompares++; $display("FAIL ovf_contents: got %0d transfers exp 4 (440,550,660,770)", got.size());
        end
    endtask

    task automatic test_flush();
        int n;
        got.delete();
        wr(4'hC, 8'h00);
        reg_ready = 1'b0;
        wr(4'h9, 8'h91);
        wr(4'hA, 8'hA2);
        wr(4'hB, 8'hB3);
        rd(4'hE);
        vectors++;
        if (data_out !== 8'h03) begin miscompares++; $display("FAIL flush_pre: got %h exp 03", data_out); end
        wr(4'hC, 8'h01);
        n = 0;
        while (reg_we !== 1'b1 && n < 10) begin n++; step(); end
        vectors++;
        if (reg_we !== 1'b1) begin miscompares++; $display("FAIL flush_issue: got we=%b exp 1", reg_we); end
        wr(4'hC, 8'h03);  // keep enable, flush
        rd(4'hE);
        vectors++;
        if (data_out !== 8'hC8) begin miscompares++; $display("FAIL flush_status: got %h exp c8", data_out); end
        rd(4'hC);
        vectors++;
        if (data_out !== 8'h01) begin miscompares++; $display("FAIL flush_ctrl: got %h exp 01", data_out); end
        vectors++;
        if ({reg_we, reg_addr, reg_data} !== {1'b1, 4'h9, 8'h91}) begin
            miscompares++; $display("FAIL flush_inflight: got we=%b a=%h d=%h exp we=1 a=9 d=91", reg_we, reg_addr, reg_data);
        end
        reg_ready = 1'b1;
        step();
        for (int i = 0; i < 6; i++) step();
        rd(4'hE);
        vectors++;
        if (data_out !== 8'h88) begin miscompares++; $display("FAIL flush_after: got %h exp 88", data_out); end
        vectors++;
        if (got.size() != 1 || got[0] !== 12'h991) begin
            miscompares++; $display("FAIL flush_issued: got %0d transfers exp 1 (991)", got.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_q [$];
        int pushed = 0;
        int n = 0;
        got.delete();
        reg_ready = 1'b1;
        wr(4'hD, 8'd0);
        wr(4'hC, 8'h01);
        while (pushed < 10 && n < 200) begin
            if (uo_out[4] !== 1'b1) begin
                address    = 4'(pushed);
                data_in    = 8'(8'h30 + 8'(pushed) * 8'd7);
                data_write = 1'b1;
                exp_q.push_back({address, data_in});
                pushed++;
            end else begin
                data_write = 1'b0;
            end
            step();
            n++;
        end
        data_write = 1'b0;
        wait_idle(60, "b2b_drain");
        vectors++;
        if (got.size() != 10) begin miscompares++; $display("FAIL b2b_count: got %0d exp 10", got.size()); end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL b2b_order%0d: got %h exp %h", i, got[i], exp_q[i]);
            end
        end
        vectors++;
        if (uo_out[5] !== 1'b0) begin miscompares++; $display("FAIL b2b_overflow: got %b exp 0", uo_out[5]); end
        rd(4'hF);
        vectors++;
        if (data_out !== 8'h09) begin miscompares++; $display("FAIL b2b_last: got %h exp 09", data_out); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_pacing_backpressure();
        test_overflow();
        test_flush();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
